data_receive: RTL

- Receive-side counterpart of the PC-to-board data path.
- Accepts bytes strobed by the UART receiver and writes them sequentially into the on-chip data memory, starting at address 0.
- Raises finish once NUM_DATA bytes have been stored.
- Sits between the UART receiver and the memory write port; the top-level controller launches the systolic computation after finish.

---
 rtl/data_receive_pkg.sv | 14 +
 rtl/data_receive_if.sv | 31 +++
 rtl/data_receive_edge_detect_rise.sv | 24 ++
 rtl/data_receive.sv | 120 ++++++++++++
 4 files changed

// File: rtl/data_receive_pkg.sv
// Shared definitions for the PC-to-board data path (receive and send sides).
// Both sides take the transfer length from here so they always agree.
package data_receive_pkg;

    localparam int unsigned MEM_ADDR_W   = 14;
    localparam int unsigned NUM_DATA_DEF = 2500;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRecv = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/data_receive_if.sv
// Byte stream from the UART receiver plus the data-memory write port.
// The master modport drives the stream and observes the write port.
interface data_receive_if;
    import data_receive_pkg::*;

    logic                  rx_done;
    logic [7:0]            rx_data;
    logic                  rx_frame_err;
    logic [MEM_ADDR_W-1:0] mem_write_sel;
    logic [7:0]            mem_write_data;
    logic                  mem_wr_en;

    modport master (
        output rx_done,
        output rx_data,
        output rx_frame_err,
        input  mem_write_sel,
        input  mem_write_data,
        input  mem_wr_en
    );

    modport slave (
        input  rx_done,
        input  rx_data,
        input  rx_frame_err,
        output mem_write_sel,
        output mem_write_data,
        output mem_wr_en
    );

endinterface

// File: rtl/data_receive_edge_detect_rise.sv
// Registered 1-bit rising-edge detector with synchronous reset.
// The pulse is combinational from the input so it aligns with the edge cycle.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic i_sig,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_sig;
        end
    end

    always_comb begin
        o_rise = i_sig & ~r_prev;
    end

endmodule

// File: rtl/data_receive.sv
// Stores bytes from the UART receiver sequentially into data memory from address 0
// and raises finish after NUM_DATA bytes; tracks framing errors and inter-byte timeouts.
module data_receive
    import data_receive_pkg::*;
#(
    parameter int unsigned NUM_DATA       = NUM_DATA_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned ERR_CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_recv_start,
    data_receive_if.slave         rx_mem,
    output logic [MEM_ADDR_W-1:0] o_bytes_received,
    output logic [ERR_CNT_W-1:0]  o_frame_err_cnt,
    output logic                  o_timeout_err,
    output logic                  o_finish
);

    localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [MEM_ADDR_W-1:0] LastIdx   = MEM_ADDR_W'(NUM_DATA - 1);
    localparam logic [TimerW-1:0]     TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
    localparam logic [ERR_CNT_W-1:0]  ErrMax    = '1;

    state_e                r_state;
    logic [MEM_ADDR_W-1:0] r_bytes;
    logic [TimerW-1:0]     r_timer;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic                  r_timeout_err;
    logic                  r_finish;
    logic                  r_wr_en;
    logic [MEM_ADDR_W-1:0] r_wr_sel;
    logic [7:0]            r_wr_data;
    logic                  w_rx_edge;

    edge_detect_rise u_rx_edge (
        .clk    (clk),
        .rst    (rst),
        .i_sig  (rx_mem.rx_done),
        .o_rise (w_rx_edge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_bytes       <= '0;
            r_timer       <= '0;
            r_err_cnt     <= '0;
            r_timeout_err <= 1'b0;
            r_finish      <= 1'b0;
            r_wr_en       <= 1'b0;
            r_wr_sel      <= '0;
            r_wr_data     <= '0;
        end else begin
            r_wr_en <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_recv_start) begin
                        r_state       <= StRecv;
                        r_bytes       <= '0;
                        r_timer       <= '0;
                        r_err_cnt     <= '0;
                        r_timeout_err <= 1'b0;
                    end
                end
                StRecv: begin
                    // A write scheduled last cycle is already on the port, so abort is safe here.
                    if (!i_recv_start) begin
                        r_state <= StIdle;
                    end else if (w_rx_edge && !rx_mem.rx_frame_err) begin
                        r_wr_en   <= 1'b1;
                        r_wr_sel  <= r_bytes;
                        r_wr_data <= rx_mem.rx_data;
                        r_bytes   <= r_bytes + MEM_ADDR_W'(1);
                        r_timer   <= '0;
                        if (r_bytes == LastIdx) begin
                            r_state  <= StDone;
                            r_finish <= 1'b1;
                        end
                    end else if (w_rx_edge) begin
                        if (r_err_cnt != ErrMax) begin
                            r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
                        end
                        r_timer <= '0;
                    end else if (r_bytes != '0) begin
                        // Idle gap only matters once the host has started sending.
                        if (r_timer == TimerLast) begin
                            r_timeout_err <= 1'b1;
                            r_timer       <= '0;
                            r_state       <= StIdle;
                        end else begin
                            r_timer <= r_timer + TimerW'(1);
                        end
                    end
                end
                StDone: begin
                    if (!i_recv_start) begin
                        r_state  <= StIdle;
                        r_finish <= 1'b0;
                    end
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        rx_mem.mem_wr_en      = r_wr_en;
        rx_mem.mem_write_sel  = r_wr_sel;
        rx_mem.mem_write_data = r_wr_data;
        o_bytes_received      = r_bytes;
        o_frame_err_cnt       = r_err_cnt;
        o_timeout_err         = r_timeout_err;
        o_finish              = r_finish;
    end

endmodule
